// File: rtl/alu_mc_responder_pkg.sv
// Shared types and defaults for the multi-cycle ALU responder.
package alu_mc_responder_pkg;

  localparam int unsigned DEFAULT_OPERAND_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one 2W accumulator.
module alu_iter_unit #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           op_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_c_o,
  output logic [2*W-1:0] result_c_o
);

  localparam int unsigned RW    = 2 * W;
  localparam int unsigned SW    = W + 1;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  logic             busy_q, busy_d;
  logic             op_div_q, op_div_d;
  logic [W-1:0]     b_q, b_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SW-1:0]    rem_sh;
  logic [SW-1:0]    diff;
  logic [SW-1:0]    sum;
  logic [RW-1:0]    acc_step;

  // Divider: upper half is the partial remainder, lower half shifts quotient bits in.
  assign rem_sh = {acc_q[RW-1:W], acc_q[W-1]};
  assign diff   = rem_sh - {1'b0, b_q};
  // Multiplier: upper half accumulates, lower half holds the shifting multiplier.
  assign sum    = {1'b0, acc_q[RW-1:W]} + (acc_q[0] ? {1'b0, b_q} : SW'(0));

  always_comb begin
    acc_step = acc_q;
    if (op_div_q) begin
      if (!diff[W]) begin
        acc_step = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end else begin
      acc_step = {sum, acc_q[W-1:1]};
    end
  end

  assign done_c_o   = busy_q && (count_q == CNT_W'(W - 1));
  assign result_c_o = acc_step;

  always_comb begin
    busy_d   = busy_q;
    op_div_d = op_div_q;
    b_d      = b_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (start_i) begin
      busy_d   = 1'b1;
      op_div_d = op_div_i;
      b_d      = b_i;
      acc_d    = {W'(0), a_i};
      count_d  = CNT_W'(0);
    end else if (busy_q) begin
      acc_d   = acc_step;
      count_d = count_q + CNT_W'(1);
      if (done_c_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      op_div_q <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      op_div_q <= op_div_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_mc_responder.sv
// Multi-cycle ALU execution core with valid/ready transaction ports on both sides.
module alu_mc_responder
  import alu_mc_responder_pkg::*;
#(
  parameter int unsigned OPERAND_MAX_DATA_WIDTH = DEFAULT_OPERAND_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0]   in_a,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0]   in_b,
  input  logic [1:0]                          in_opcode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*OPERAND_MAX_DATA_WIDTH-1:0] out_result,
  output logic                                out_error
);

  localparam int unsigned W  = OPERAND_MAX_DATA_WIDTH;
  localparam int unsigned RW = 2 * W;

  fsm_state_t    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  alu_op_t       op_q, op_d;
  logic [RW-1:0] result_q, result_d;
  logic          error_q, error_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic          iter_start_c;
  logic          iter_done_c;
  logic [RW-1:0] iter_result_c;

  alu_iter_unit #(
    .W (W)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (iter_start_c),
    .op_div_i   (in_opcode == OP_DIV),
    .a_i        (in_a),
    .b_i        (in_b),
    .done_c_o   (iter_done_c),
    .result_c_o (iter_result_c)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    error_d      = error_q;
    valid_d      = valid_q;
    ready_d      = ready_q;
    iter_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d          = in_a;
          b_d          = in_b;
          op_d         = alu_op_t'(in_opcode);
          ready_d      = 1'b0;
          state_d      = ST_EXEC;
          // Divide by zero never enters the iterative unit.
          iter_start_c = (in_opcode == OP_MUL) ||
                         ((in_opcode == OP_DIV) && (in_b != W'(0)));
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = RW'(a_q) + RW'(b_q);
            error_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end
          OP_SUB: begin
            result_d = RW'(a_q) - RW'(b_q);
            error_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end
          default: begin
            if ((op_q == OP_DIV) && (b_q == W'(0))) begin
              result_d = {a_q, {W{1'b1}}};
              error_d  = 1'b1;
              valid_d  = 1'b1;
              state_d  = ST_DONE;
            end else if (iter_done_c) begin
              result_d = iter_result_c;
              error_d  = 1'b0;
              valid_d  = 1'b1;
              state_d  = ST_DONE;
            end
          end
        endcase
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_error  = error_q;

endmodule

// File: tb/tb_alu_mc_responder.sv
// Directed plus randomized transactions against an arithmetic reference model.
module tb_alu_mc_responder;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_error;

  int checks   = 0;
  int failures = 0;

  alu_mc_responder #(
    .OPERAND_MAX_DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input int a, input int b, input int op);
    case (op)
      0:       return 16'((a + b) & 16'hFFFF);
      1:       return 16'((a - b) & 16'hFFFF);
      2:       return 16'(a * b);
      default: return (b == 0) ? 16'((a << 8) | 8'hFF) : 16'(((a % b) << 8) | (a / b));
    endcase
  endfunction

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input int hold);
    int          n;
    bit          seen;
    logic [15:0] exp_r;
    logic        exp_e;
    int          exp_l;
    exp_r = model_result(int'(a), int'(b), int'(op));
    exp_e = (op == 2'd3) && (b == 8'd0);
    exp_l = ((op == 2'd2) || ((op == 2'd3) && (b != 8'd0))) ? W : 1;

    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'(1));
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    in_opcode = 2'($urandom);
    check("busy_in_ready", 32'(in_ready), 32'(0));

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = out_valid;
    end
    check("latency", 32'(n), 32'(exp_l));
    check("result", 32'(out_result), 32'(exp_r));
    check("error", 32'(out_error), 32'(exp_e));

    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_opcode = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold_result", 32'(out_result), 32'(exp_r));
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", 32'(out_valid), 32'(0));
    check("post_hs_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_opcode = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_result", 32'(out_result), 32'(0));
    check("rst_out_error", 32'(out_error), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_accept_valid", 32'(out_valid), 32'(0));
    check("rst_no_accept_ready", 32'(in_ready), 32'(1));

    // Directed cases, including the required boundary values.
    do_txn(8'hFF, 8'hFF, 2'd0, 0);
    do_txn(8'h03, 8'h05, 2'd1, 0);
    do_txn(8'hFF, 8'hFF, 2'd2, 0);
    do_txn(8'd200, 8'd7, 2'd3, 0);
    do_txn(8'h55, 8'h00, 2'd3, 0);
    do_txn(8'h3C, 8'h11, 2'd2, 5);
    do_txn(8'h00, 8'h00, 2'd1, 0);
    do_txn(8'hFF, 8'h01, 2'd3, 2);
    do_txn(8'h07, 8'hFF, 2'd3, 0);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = 8'h0F;
    in_b      = 8'h0F;
    in_opcode = 2'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'(0));
    check("midrst_idle_ready", 32'(in_ready), 32'(1));

    for (int t = 0; t < 40; t++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      do_txn(ra, rb, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc_responder.md
Name: alu_mc_responder

Overview:
- Responder side of the ALU input/output transaction interface: accepts one operand/opcode transaction per valid/ready handshake, executes it over one or more cycles, and presents the result on a valid/ready output port.
- Sits between the ALU_in bus driver and the ALU_out bus monitor as the multi-cycle ALU execution core.
- Add and subtract take one cycle; multiply (shift-add) and divide (restoring) are iterative.
- Single transaction in flight; no internal queue.

Parameters:
OPERAND_MAX_DATA_WIDTH, 8, operand width W in bits; result width is 2W.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  transaction present on in_a/in_b/in_opcode
in_ready  output  1  responder can accept a transaction
in_a  input  W  operand A, unsigned
in_b  input  W  operand B, unsigned
in_opcode  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  2W  result
out_error  output  1  divide by zero flagged for this result

Behaviour:
- Reset: with rst high at a clock edge, the FSM goes to IDLE. After that edge, in_ready=1 (when rst is low), out_valid=0, out_result=0, out_error=0, and the iteration counter and internal registers are cleared.
- Reset mid-operation or mid-DONE: the transaction is discarded and no result is emitted.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a, b and opcode, then go to EXEC with count=0.
  - in_ready=0 in EXEC and DONE.
- EXEC, ADD/SUB and divide by zero: complete in the first EXEC cycle and go to DONE.
- EXEC, MUL/DIV with b≠0: one iteration per cycle, W iterations, then go to DONE.
- DONE:
  - out_valid=1. out_result and out_error are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - in_ready rises the cycle after the output handshake. There is no same-cycle accept.
- Latency, handshake edge k to first out_valid cycle:
  - ADD/SUB and divide by zero: out_valid is high after edge k+1.
  - MUL/DIV: out_valid is high after edge k+W.
- Arithmetic (a, b unsigned):
  - ADD: zero-extended a+b; carry appears in bit W.
  - SUB: (a−b) mod 2^(2W), i.e. the two's-complement result in 2W bits.
  - MUL: full 2W-bit product a*b.
  - DIV: out_result = {remainder[W-1:0], quotient[W-1:0]}.
  - DIV with b=0: out_error=1 and out_result = {a, W'h all-ones}.
  - out_error=0 for all other results.
- in_a, in_b and in_opcode are ignored whenever in_ready=0.

Decomposition:
- Shared package (parameters):
  - opcode enum alu_op_t {OP_ADD, OP_SUB, OP_MUL, OP_DIV}, 2 bits.
  - fsm state enum.
  - OPERAND_MAX_DATA_WIDTH default.
- Sub-module alu_iter_unit: the shift-add multiplier and restoring divider.
  - Shares one accumulator/shift register and a counter of $clog2(W)+1 bits.
  - start/done interface to the FSM.

Test Plan:
- Reset sequence:
  - Assert rst for 2 cycles with in_valid=1 → no accept.
  - After reset: in_ready=1, out_valid=0, out_result=0x0000.
- ADD a=0xFF b=0xFF, out_ready=1 → out_result=0x01FE and out_error=0, with out_valid after edge k+1.
- SUB a=0x03 b=0x05 → out_result=0xFFFE.
- MUL a=0xFF b=0xFF → out_result=0xFE01, with out_valid first high after edge k+8.
- DIV cases:
  - a=200 b=7 → out_result=0x041C.
  - a=0x55 b=0x00 → out_result=0x55FF, out_error=1, valid after k+1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles during DONE → result stable, in_ready=0, new in_valid ignored.
  - Assert rst during MUL EXEC → no result emitted, IDLE after the reset edge.
